// File: rtl/mem_resp_pkg.sv
// Shared defaults, widths and FSM state type for the memory responder.
package mem_resp_pkg;

    localparam int unsigned AW_DEF    = 6;
    localparam int unsigned DW_DEF    = 8;
    localparam int unsigned DEPTH_DEF = 48;
    localparam int unsigned CNT_W     = 16;
    localparam int unsigned BLEN_W    = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } burst_state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear and increment enable.
module sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);

    // Count up on inc, stick at all-ones, clear takes priority.
    always_ff @(posedge clk) begin
        if (clr) begin
            q <= '0;
        end else if (inc && (q != '1)) begin
            q <= q + 1'b1;
        end
    end

endmodule

// File: rtl/mem_responder.sv
// Single-port memory responder with range checking, access counters and
// burst-length tracking.
module mem_responder
    import mem_resp_pkg::*;
#(
    parameter int unsigned AW    = AW_DEF,
    parameter int unsigned DW    = DW_DEF,
    parameter int unsigned DEPTH = DEPTH_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              wr,
    input  logic [AW-1:0]     addr,
    input  logic [DW-1:0]     wdata,
    output logic [DW-1:0]     rdata,
    output logic              rvalid,
    output logic              err,
    output logic              burst_done,
    output logic [BLEN_W-1:0] burst_len,
    output logic [CNT_W-1:0]  wr_cnt,
    output logic [CNT_W-1:0]  rd_cnt
);

    // One extra bit so DEPTH == 2**AW is still representable.
    localparam logic [AW:0] DEPTH_LIM = (AW+1)'(DEPTH);

    logic [DW-1:0] mem [DEPTH];

    logic in_range;
    logic wr_hit;
    logic rd_hit;

    burst_state_t      state, state_next;
    logic [BLEN_W-1:0] count, count_next;
    logic [BLEN_W-1:0] len_next;
    logic              done_next;

    assign in_range = ({1'b0, addr} < DEPTH_LIM);
    assign wr_hit   = en &  wr & in_range;
    assign rd_hit   = en & ~wr & in_range;

    // Storage: reset wipes every location, in-range writes update one.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem <= '{default: '0};
        end else if (wr_hit) begin
            mem[addr] <= wdata;
        end
    end

    // Registered response: read data, valid and out-of-range pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata  <= '0;
            rvalid <= 1'b0;
            err    <= 1'b0;
        end else begin
            rvalid <= rd_hit;
            err    <= en & ~in_range;
            rdata  <= rd_hit ? mem[addr] : '0;
        end
    end

    sat_counter #(.W(CNT_W)) u_wr_cnt (
        .clk (clk),
        .clr (rst),
        .inc (wr_hit),
        .q   (wr_cnt)
    );

    sat_counter #(.W(CNT_W)) u_rd_cnt (
        .clk (clk),
        .clr (rst),
        .inc (rd_hit),
        .q   (rd_cnt)
    );

    // Burst FSM state, running count and reported length registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            count      <= '0;
            burst_len  <= '0;
            burst_done <= 1'b0;
        end else begin
            state      <= state_next;
            count      <= count_next;
            burst_len  <= len_next;
            burst_done <= done_next;
        end
    end

    // Burst FSM next-state: count every en cycle, report when en drops.
    always_comb begin
        state_next = state;
        count_next = count;
        len_next   = burst_len;
        done_next  = 1'b0;
        case (state)
            IDLE: begin
                if (en) begin
                    state_next = BURST;
                    count_next = BLEN_W'(1);
                end
            end
            BURST: begin
                if (en) begin
                    if (count != '1) begin
                        count_next = count + 1'b1;
                    end
                end else begin
                    state_next = IDLE;
                    len_next   = count;
                    done_next  = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter AW, 6, address width in bits.
REQ-002 Parameter DW, 8, data width in bits.
REQ-003 Parameter DEPTH, 48, number of implemented locations; legal addresses are 0..DEPTH-1, and DEPTH SHALL NOT exceed 2**AW.
REQ-004 clk  input  1  system clock, 25 MHz nominal; all logic is on the rising edge.
REQ-005 rst  input  1  reset, synchronous and active-high.
REQ-006 en  input  1  transaction enable; each cycle with en=1 is one transaction.
REQ-007 wr  input  1  direction: 1 = write, 0 = read; sampled only when en=1.
REQ-008 addr  input  AW  transaction address; sampled only when en=1.
REQ-009 wdata  input  DW  write data; sampled only when en=1 and wr=1.
REQ-010 rdata  output  DW  read data; valid only while rvalid=1.
REQ-011 rvalid  output  1  one-cycle pulse marking rdata valid.
REQ-012 err  output  1  one-cycle pulse for an out-of-range access.
REQ-013 burst_done  output  1  one-cycle pulse at the end of a burst.
REQ-014 burst_len  output  8  transaction count of the last completed burst.
REQ-015 wr_cnt  output  16  total accepted writes, saturating.
REQ-016 rd_cnt  output  16  total accepted reads, saturating.

Function
REQ-017 Write: en=1, wr=1 and addr<DEPTH at edge N SHALL store wdata at mem[addr] at edge N and increment wr_cnt.
REQ-018 Read: en=1, wr=0 and addr<DEPTH at edge N SHALL drive rdata=mem[addr] with rvalid=1 during cycle N+1 (latency 1), and increment rd_cnt.
REQ-019 A read of an address written at the previous edge SHALL return the new data.
REQ-020 Out-of-range: en=1 and addr>=DEPTH SHALL pulse err=1 in cycle N+1 and leave memory and both counters unchanged; for a read, rvalid SHALL stay 0 and rdata SHALL be 0.
REQ-021 When rvalid=0, rdata SHALL be 0.
REQ-022 wr_cnt and rd_cnt SHALL saturate at 65535 and never wrap.
REQ-023 Burst tracking SHALL use an FSM with two states:
  - IDLE: en=1 -> BURST, load the transaction count with 1.
  - BURST: en=1 -> stay in BURST, count+1, saturating at 255.
  - BURST: en=0 -> IDLE, latch count into burst_len, pulse burst_done in the following cycle.
REQ-024 The burst count SHALL include transactions that raise err.
REQ-025 burst_len SHALL hold its value until the next burst_done.
REQ-026 A one-cycle en pulse SHALL produce burst_len=1.
REQ-027 The inputs wr, addr and wdata SHALL be ignored when en=0.

Reset
REQ-028 rst=1 at an edge SHALL clear all memory locations to 0 and return the FSM to IDLE.
REQ-029 rst=1 SHALL clear rdata, rvalid, err, burst_done, burst_len, wr_cnt and rd_cnt to 0.
REQ-030 Reset SHALL take priority over any transaction at the same edge; rst during BURST SHALL abandon the burst without a burst_done pulse.
REQ-031 The first transaction SHALL be accepted at the first edge with rst=0.

Structure
REQ-032 Package mem_resp_pkg SHALL hold:
  - the default AW, DW and DEPTH values;
  - the FSM state enum (IDLE, BURST);
  - the counter width constant (16).
REQ-033 Sub-module sat_counter SHALL implement the parameterised-width saturating counter with synchronous clear and increment enable, and SHALL be instantiated for wr_cnt and rd_cnt.

Verification
REQ-034 Write then read: write addr=12, wdata=0xA5; read addr=12 next cycle -> rdata=0xA5 with rvalid=1 one cycle after the read; wr_cnt=1, rd_cnt=1.
REQ-035 Five-cycle burst: en high for 5 cycles with addresses 12, 14, 23, 48, 56 (writes to 12 and 14, reads of 23, 48 and 56) -> err pulses for 48 and 56; burst_len=5 with one burst_done pulse after en falls; wr_cnt=2, rd_cnt=1.
REQ-036 Out-of-range write: write addr=50, wdata=0x3C -> err=1; a later read of addr=50 gives err=1, rvalid=0, rdata=0.
REQ-037 Reset mid-burst: rst=1 in the 3rd cycle of an en burst -> no burst_done; burst_len=0; counters=0; a read of a previously written address returns 0.
REQ-038 Saturation: 300 consecutive en=1 cycles -> burst_len=255; with wr_cnt preloaded near 65535 by a long write stream -> wr_cnt holds at 65535.
